jtpopeye_sec_master: RTL and testbench

Bus initiator for the Popeye-board security barrel shifter. It runs the full CPU-side transaction: push the low byte, push the high byte, load the shift, wait for the shifter, read back. It sits between a requesting agent (boot self-test or protection-patch engine) and the security chip's `cs/A0/rd_n/wr_n` port. It returns `result = (hi << shift) | (lo >> (8 - shift))`, truncated to 8 bits.

---
 rtl/jtpopeye_sec_master_if.sv | 25 ++
 rtl/jtpopeye_sec_master.sv | 100 ++++++++++
 tb/tb_jtpopeye_sec_master.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpopeye_sec_master_if.sv
// jtpopeye_sec_master_if: request side (cen, start, hi, lo, shift -> busy, done, result) and security chip side (cs, A0, rd_n, wr_n, dout <- din) of the barrel-shifter initiator
interface jtpopeye_sec_master_if;
  logic       cen;
  logic       start;
  logic [7:0] hi;
  logic [7:0] lo;
  logic [2:0] shift;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cs;
  logic       A0;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] dout;
  logic [7:0] din;
  modport master (
    input  cen, start, hi, lo, shift, din,
    output busy, done, result, cs, A0, rd_n, wr_n, dout
  );
  modport slave (
    output cen, start, hi, lo, shift, din,
    input  busy, done, result, cs, A0, rd_n, wr_n, dout
  );
endinterface

// File: rtl/jtpopeye_sec_master.sv
// jtpopeye_sec_master: pushes lo, hi and shift into the security shifter, waits SETTLE cen periods, reads back result
//   clk, rst : clock and asynchronous active-high reset
//   bus      : master modport; request inputs and result/status outputs, plus the cs/A0/rd_n/wr_n/dout/din chip port
module jtpopeye_sec_master #(
  parameter int SETTLE = 1
) (
  input logic                   clk,
  input logic                   rst,
  jtpopeye_sec_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, ARM, WR_LO, WR_HI, WR_SH, WAIT, RD, CAPT} state_t;
  localparam logic [2:0] SETTLE_N = 3'(SETTLE);
  state_t     r_state;
  logic [7:0] r_hi, r_lo, r_result, r_dout;
  logic [2:0] r_shift, r_cnt;
  logic       r_busy, r_done, r_cs, r_a0, r_rd_n, r_wr_n;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cs     = r_cs;
  assign bus.A0     = r_a0;
  assign bus.rd_n   = r_rd_n;
  assign bus.wr_n   = r_wr_n;
  assign bus.dout   = r_dout;
  // acceptance ignores cen; every later phase lasts exactly one cen period and
  // the shifter samples it on the cen edge that ends it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_hi     <= 8'd0;
      r_lo     <= 8'd0;
      r_shift  <= 3'd0;
      r_cnt    <= 3'd0;
      r_result <= 8'd0;
      r_dout   <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs     <= 1'b0;
      r_a0     <= 1'b0;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start) begin
          r_hi    <= bus.hi;
          r_lo    <= bus.lo;
          r_shift <= bus.shift;
          r_busy  <= 1'b1;
          r_state <= ARM;
        end
      end else if (bus.cen) begin
        case (r_state)
          ARM: begin
            r_cs    <= 1'b1;
            r_a0    <= 1'b1;
            r_wr_n  <= 1'b0;
            r_dout  <= r_lo;
            r_state <= WR_LO;
          end
          WR_LO: begin
            r_dout  <= r_hi;
            r_state <= WR_HI;
          end
          WR_HI: begin
            r_a0    <= 1'b0;
            r_dout  <= {5'd0, r_shift};
            r_state <= WR_SH;
          end
          WR_SH: begin
            r_cs    <= 1'b0;
            r_wr_n  <= 1'b1;
            r_cnt   <= SETTLE_N;
            r_state <= WAIT;
          end
          WAIT: begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
              r_cs    <= 1'b1;
              r_a0    <= 1'b0;
              r_rd_n  <= 1'b0;
              r_state <= RD;
            end
          end
          RD: begin
            r_cs    <= 1'b0;
            r_rd_n  <= 1'b1;
            r_state <= CAPT;
          end
          CAPT: begin
            r_result <= bus.din;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_jtpopeye_sec_master.sv
// tb_jtpopeye_sec_master: random and directed transactions on SETTLE=1 and SETTLE=4 instances against a shifter chip model and the shift formula
module tb_jtpopeye_sec_master;
  logic       clk, rst, cen, start_a, start_b;
  logic [7:0] hi, lo;
  logic [2:0] sh;
  int         div = 1;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         prot_err = 0;
  logic       cs_v[2], a0_v[2], rd_v[2], wr_v[2], busy_v[2], done_v[2];
  logic [7:0] dout_v[2], res_v[2];
  logic [7:0] f_new[2], f_old[2], r_res[2], din_m[2];
  logic [2:0] f_sh[2];

  jtpopeye_sec_master_if ia();
  jtpopeye_sec_master_if ib();
  assign ia.cen = cen;
  assign ia.start = start_a;
  assign ia.hi = hi;
  assign ia.lo = lo;
  assign ia.shift = sh;
  assign ia.din = din_m[0];
  assign ib.cen = cen;
  assign ib.start = start_b;
  assign ib.hi = hi;
  assign ib.lo = lo;
  assign ib.shift = sh;
  assign ib.din = din_m[1];
  assign cs_v[0] = ia.cs;
  assign a0_v[0] = ia.A0;
  assign rd_v[0] = ia.rd_n;
  assign wr_v[0] = ia.wr_n;
  assign busy_v[0] = ia.busy;
  assign done_v[0] = ia.done;
  assign dout_v[0] = ia.dout;
  assign res_v[0] = ia.result;
  assign cs_v[1] = ib.cs;
  assign a0_v[1] = ib.A0;
  assign rd_v[1] = ib.rd_n;
  assign wr_v[1] = ib.wr_n;
  assign busy_v[1] = ib.busy;
  assign done_v[1] = ib.done;
  assign dout_v[1] = ib.dout;
  assign res_v[1] = ib.result;

  jtpopeye_sec_master #(.SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
  jtpopeye_sec_master #(.SETTLE(4)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    cen <= (cyc % div) == 0;
  end

  // security chip: two-entry FIFO, shift register, result register recomputed every cen edge
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        f_new[k] <= 8'd0;
        f_old[k] <= 8'd0;
        f_sh[k]  <= 3'd0;
        r_res[k] <= 8'd0;
        din_m[k] <= 8'd0;
      end else if (cen) begin
        if (cs_v[k] && !wr_v[k] && a0_v[k]) begin
          f_new[k] <= dout_v[k];
          f_old[k] <= f_new[k];
        end
        if (cs_v[k] && !wr_v[k] && !a0_v[k]) f_sh[k] <= dout_v[k][2:0];
        r_res[k] <= 8'(({f_new[k], f_old[k]} << f_sh[k]) >> 8);
        if (cs_v[k] && !rd_v[k]) din_m[k] <= r_res[k];
      end

  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if ((!rd_v[k] && !wr_v[k]) || (rd_v[k] && wr_v[k] && cs_v[k]) || (a0_v[k] && wr_v[k]))
        prot_err <= prot_err + 1;

  function automatic logic [7:0] ref_shift(input logic [7:0] h, input logic [7:0] l, input logic [2:0] s);
    logic [15:0] a, b;
    a = 16'(h) << s;
    b = 16'(l) >> (4'd8 - {1'b0, s});
    return a[7:0] | b[7:0];
  endfunction

  task automatic run(input int k, input logic [7:0] h, input logic [7:0] l, input logic [2:0] s, output logic [7:0] res);
    int settle, ncen, nclk, nwr, nrd, gap;
    bit seen_wr, seen_rd, got;
    logic [7:0] exp_r;
    settle = (k == 0) ? 1 : 4;
    exp_r = ref_shift(h, l, s);
    ncen = 0; nclk = 0; nwr = 0; nrd = 0; gap = 0;
    seen_wr = 0; seen_rd = 0; got = 0;
    @(negedge clk);
    hi = h; lo = l; sh = s;
    if (k == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    while (!got && nclk < 400) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (!wr_v[k]) begin nwr++; seen_wr = 1; end
      if (!rd_v[k]) begin nrd++; seen_rd = 1; end
      if (seen_wr && !seen_rd && !cs_v[k]) gap++;
      if (done_v[k]) got = 1;
      else begin
        @(posedge clk);
        nclk++;
        if (cen) ncen++;
      end
    end
    res = res_v[k];
    checks++; if (!got) begin errors++; $display("FAIL run%0d timeout: no done within %0d clks", k, nclk); end
    checks++; if (res_v[k] !== exp_r) begin errors++; $display("FAIL run%0d result hi=%h lo=%h sh=%0d: got %h want %h", k, h, l, s, res_v[k], exp_r); end
    checks++; if (ncen !== 6 + settle) begin errors++; $display("FAIL run%0d latency: got %0d cen edges want %0d", k, ncen, 6 + settle); end
    checks++; if (nwr !== 3 * div) begin errors++; $display("FAIL run%0d wr_n low cycles: got %0d want %0d", k, nwr, 3 * div); end
    checks++; if (nrd !== div) begin errors++; $display("FAIL run%0d rd_n low cycles: got %0d want %0d", k, nrd, div); end
    checks++; if (gap !== settle * div) begin errors++; $display("FAIL run%0d settle gap: got %0d want %0d", k, gap, settle * div); end
    checks++; if (busy_v[k] !== 1'b0) begin errors++; $display("FAIL run%0d busy at done: got %b want 0", k, busy_v[k]); end
    @(negedge clk);
    checks++; if (done_v[k] !== 1'b0) begin errors++; $display("FAIL run%0d done width: got %b want 0", k, done_v[k]); end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy_v[k], done_v[k], cs_v[k], a0_v[k], rd_v[k], wr_v[k]} !== 6'b000011) begin
        errors++;
        $display("FAIL reset%0d ctrl: got %b want 000011", k, {busy_v[k], done_v[k], cs_v[k], a0_v[k], rd_v[k], wr_v[k]});
      end
      checks++; if (res_v[k] !== 8'd0) begin errors++; $display("FAIL reset%0d result: got %h want 00", k, res_v[k]); end
      checks++; if (dout_v[k] !== 8'd0) begin errors++; $display("FAIL reset%0d dout: got %h want 00", k, dout_v[k]); end
    end
  endtask

  task automatic test_basic;
    logic [7:0] r;
    div = 1;
    run(0, 8'h81, 8'hC3, 3'd3, r);
    checks++; if (r !== 8'h0E) begin errors++; $display("FAIL basic: got %h want 0e", r); end
  endtask

  task automatic test_edges;
    logic [7:0] r;
    run(0, 8'h81, 8'hC3, 3'd0, r);
    checks++; if (r !== 8'h81) begin errors++; $display("FAIL shift0: got %h want 81", r); end
    run(0, 8'h81, 8'hC3, 3'd7, r);
    checks++; if (r !== 8'hE1) begin errors++; $display("FAIL shift7: got %h want e1", r); end
  endtask

  task automatic test_random;
    logic [7:0] r;
    for (int i = 0; i < 6; i++) run(0, 8'($urandom), 8'($urandom), 3'($urandom), r);
  endtask

  task automatic test_cen_div;
    logic [7:0] r;
    div = 3;
    repeat (4) @(negedge clk);
    run(0, 8'h81, 8'hC3, 3'd3, r);
    checks++; if (r !== 8'h0E) begin errors++; $display("FAIL cen_div basic: got %h want 0e", r); end
    for (int i = 0; i < 3; i++) run(0, 8'($urandom), 8'($urandom), 3'($urandom), r);
    run(1, 8'($urandom), 8'($urandom), 3'($urandom), r);
    div = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_settle;
    logic [7:0] r;
    run(1, 8'h81, 8'hC3, 3'd3, r);
    checks++; if (r !== 8'h0E) begin errors++; $display("FAIL settle4 basic: got %h want 0e", r); end
    for (int i = 0; i < 3; i++) run(1, 8'($urandom), 8'($urandom), 3'($urandom), r);
  endtask

  task automatic test_reset_mid;
    int n;
    bit hit;
    logic [7:0] r;
    @(negedge clk);
    hi = 8'h5A; lo = 8'hA5; sh = 3'd2; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!(a0_v[0] === 1'b1 && wr_v[0] === 1'b0 && dout_v[0] === 8'h5A) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL reset_mid: WR_HI not reached in %0d clks", n); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cs_v[0], rd_v[0], wr_v[0], busy_v[0]} !== 4'b0110) begin
      errors++;
      $display("FAIL reset_mid bus: got cs,rd_n,wr_n,busy=%b want 0110", {cs_v[0], rd_v[0], wr_v[0], busy_v[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    hit = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) hit = 1;
    end
    checks++; if (hit) begin errors++; $display("FAIL reset_mid resume: got done/busy after reset want none"); end
    run(0, 8'hFF, 8'h00, 3'd4, r);
    checks++; if (r !== 8'hF0) begin errors++; $display("FAIL after_reset: got %h want f0", r); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] th[4], tl[4];
    logic [2:0] ts[4];
    int n;
    bit got;
    for (int i = 0; i < 4; i++) begin
      th[i] = 8'($urandom);
      tl[i] = 8'($urandom);
      ts[i] = 3'($urandom);
    end
    ts[0] = 3'd0;
    ts[1] = 3'd7;
    div = 1;
    @(negedge clk);
    hi = th[0]; lo = tl[0]; sh = ts[0]; start_a = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL b2b%0d accept: busy got %b want 1", i, busy_v[0]); end
      if (i < 3) begin
        hi = th[i+1]; lo = tl[i+1]; sh = ts[i+1];
      end else begin
        hi = ~th[i]; lo = ~tl[i]; sh = ~ts[i];
      end
      n = 0;
      got = 0;
      while (!got && n < 50) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        got = done_v[0];
      end
      checks++; if (!got || n !== 7) begin errors++; $display("FAIL b2b%0d latency: got %0d clks want 7", i, n); end
      checks++;
      if (res_v[0] !== ref_shift(th[i], tl[i], ts[i])) begin
        errors++;
        $display("FAIL b2b%0d result: got %h want %h", i, res_v[0], ref_shift(th[i], tl[i], ts[i]));
      end
      checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL b2b%0d busy at done: got %b want 0", i, busy_v[0]); end
      if (i == 3) start_a = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL b2b end: busy got %b want 0", busy_v[0]); end
  endtask

  task automatic test_protocol;
    checks++; if (prot_err !== 0) begin errors++; $display("FAIL protocol: got %0d bad cycles want 0", prot_err); end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    hi = 8'd0;
    lo = 8'd0;
    sh = 3'd0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_edges;
    test_random;
    test_cen_div;
    test_settle;
    test_reset_mid;
    test_back_to_back;
    test_protocol;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
